// File: rtl/rll_key_loader.sv
// Serial key loader for an RLL-locked core: shifts a KEY_W-bit key in LSB first, commits it atomically,
// and gates the core's primary outputs until a checked key is active. Optional macro: KEY_PARITY_CHECK_EN.
module rll_key_loader #(
  parameter int KEY_W = 32,
  parameter int PO_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_req,
  input  logic             clear,
  input  logic             key_sdata,
  input  logic             key_svalid,
  output logic             key_sready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             err,
  input  logic [PO_W-1:0]  po_in,
  output logic [PO_W-1:0]  po_out
);

`ifdef KEY_PARITY_CHECK_EN
  localparam int NBEATS = KEY_W + 1;
`else
  localparam int NBEATS = KEY_W;
`endif
  localparam int CW = $clog2(KEY_W + 2);
  localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, ARMED, ERROR} state_t;

  state_t           state;
  logic [KEY_W-1:0] shadow;
  logic [CW-1:0]    cnt;
  logic             check_pass;

`ifdef KEY_PARITY_CHECK_EN
  logic parity_bit;
  logic err_q;
  assign err        = err_q;
  // Even parity over the key bits plus the trailing parity beat.
  assign check_pass = ~(^shadow ^ parity_bit);
`else
  assign err        = 1'b0;
  assign check_pass = 1'b1;
`endif

  // The shadow register fills beat by beat; key_out only ever sees a complete, checked key.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shadow     <= '0;
      cnt        <= '0;
      key_out    <= '0;
      key_valid  <= 1'b0;
      busy       <= 1'b0;
      key_sready <= 1'b0;
      po_out     <= '0;
`ifdef KEY_PARITY_CHECK_EN
      parity_bit <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      po_out <= key_valid ? po_in : '0;
      if (clear) begin
        state      <= IDLE;
        shadow     <= '0;
        cnt        <= '0;
        key_out    <= '0;
        key_valid  <= 1'b0;
        busy       <= 1'b0;
        key_sready <= 1'b0;
`ifdef KEY_PARITY_CHECK_EN
        parity_bit <= 1'b0;
        err_q      <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE, ARMED, ERROR: begin
            if (load_req) begin
              state      <= SHIFT;
              shadow     <= '0;
              cnt        <= '0;
              key_out    <= '0;
              key_valid  <= 1'b0;
              busy       <= 1'b1;
              key_sready <= 1'b1;
`ifdef KEY_PARITY_CHECK_EN
              parity_bit <= 1'b0;
              err_q      <= 1'b0;
`endif
            end
          end
          SHIFT: begin
            if (key_svalid && key_sready) begin
              // The shift term vanishes for the parity beat, leaving the key bits intact.
              shadow <= shadow | (KEY_W'(key_sdata) << cnt);
              cnt    <= cnt + CW'(1);
`ifdef KEY_PARITY_CHECK_EN
              if (cnt == CW'(KEY_W)) parity_bit <= key_sdata;
`endif
              if (cnt == LAST_BEAT) begin
                state      <= CHECK;
                key_sready <= 1'b0;
              end
            end
          end
          CHECK: begin
            busy <= 1'b0;
            if (check_pass) begin
              state     <= ARMED;
              key_out   <= shadow;
              key_valid <= 1'b1;
            end else begin
              state <= ERROR;
`ifdef KEY_PARITY_CHECK_EN
              err_q <= 1'b1;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rll_key_loader.sv
// Self-checking bench for rll_key_loader: a bit-queue reference model compared every cycle, plus
// directed loads with literal expected values. Honours KEY_PARITY_CHECK_EN the same way as the design.
module tb_rll_key_loader;

`ifdef KEY_PARITY_CHECK_EN
  localparam int NBEATS = 33;
  localparam bit PARITY_ON = 1'b1;
`else
  localparam int NBEATS = 32;
  localparam bit PARITY_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, load_req, clear, key_sdata, key_svalid;
  logic        key_sready, key_valid, busy, err;
  logic [31:0] key_out, po_in, po_out;
  bit          po_vary;

  int checks = 0;
  int passed = 0;

  rll_key_loader #(.KEY_W(32), .PO_W(32)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .clear(clear),
    .key_sdata(key_sdata), .key_svalid(key_svalid), .key_sready(key_sready),
    .key_out(key_out), .key_valid(key_valid), .busy(busy), .err(err),
    .po_in(po_in), .po_out(po_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    else
      passed++;
  endtask

  // Reference model: a load is "a queue of accepted bits"; once full it is judged one cycle later.
  logic [31:0] m_key_out, m_po;
  bit          m_valid, m_err, m_loading, m_judging;
  bit          m_bits[$];

  always @(posedge clk) begin
    logic [31:0] assembled;
    bit          par;
    m_po = (rst || !m_valid) ? 32'h0 : po_in;
    if (rst || clear) begin
      m_loading = 0; m_judging = 0; m_valid = 0; m_err = 0; m_key_out = 0;
      m_bits.delete();
    end else if (m_judging) begin
      m_judging = 0;
      assembled = 0;
      par = 0;
      foreach (m_bits[i]) begin
        if (i < 32) assembled[i] = m_bits[i];
        par ^= m_bits[i];
      end
      if (!PARITY_ON || !par) begin
        m_key_out = assembled;
        m_valid = 1;
      end else begin
        m_err = 1;
      end
    end else if (m_loading) begin
      if (key_svalid) begin
        m_bits.push_back(key_sdata);
        if (m_bits.size() == NBEATS) begin
          m_loading = 0;
          m_judging = 1;
        end
      end
    end else if (load_req) begin
      m_loading = 1; m_valid = 0; m_err = 0; m_key_out = 0;
      m_bits.delete();
    end
    #1;
    checkOutput("key_out", key_out, m_key_out);
    checkOutput("key_valid", {31'b0, key_valid}, {31'b0, m_valid});
    checkOutput("err", {31'b0, err}, {31'b0, m_err});
    checkOutput("busy", {31'b0, busy}, {31'b0, m_loading | m_judging});
    checkOutput("key_sready", {31'b0, key_sready}, {31'b0, m_loading});
    checkOutput("po_out", po_out, m_po);
  end

  // Drives one cycle of inputs from a falling edge and returns at the next falling edge.
  task automatic applyStimulus(input logic lr, input logic clr, input logic sv, input logic sd);
    load_req   = lr;
    clear      = clr;
    key_svalid = sv;
    key_sdata  = sd;
    if (po_vary) po_in = {po_in[30:0], po_in[31]} ^ 32'h0000_0101;
    @(negedge clk);
  endtask

  task automatic loadKey(input logic [31:0] key, input logic par, input int gap);
    for (int i = 0; i < NBEATS; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, (i < 32) ? key[i] : par);
      if (i < NBEATS - 1)
        for (int g = 0; g < gap; g++) begin
          applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
          checkOutput("stall_busy", {31'b0, busy}, 32'h1);
        end
    end
  endtask

  initial begin
    logic [31:0] k;
    rst = 1'b1; load_req = 1'b0; clear = 1'b0; key_sdata = 1'b0; key_svalid = 1'b0;
    po_in = 32'hFFFF_FFFF; po_vary = 0;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_key_out", key_out, 32'h0);
    checkOutput("reset_key_valid", {31'b0, key_valid}, 32'h0);
    checkOutput("reset_po_out", po_out, 32'h0);
    po_vary = 1;

    // Clean back-to-back load
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    loadKey(32'hA5C3_0F96, 1'b0, 0);
    checkOutput("check_cycle_valid", {31'b0, key_valid}, 32'h0);
    checkOutput("check_cycle_busy", {31'b0, busy}, 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("clean_key_out", key_out, 32'hA5C3_0F96);
    checkOutput("clean_key_valid", {31'b0, key_valid}, 32'h1);
    checkOutput("clean_po_gated", po_out, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("clean_po_follows", po_out, po_in);

    // Stalled load, started from ARMED
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("reload_valid_drop", {31'b0, key_valid}, 32'h0);
    loadKey(32'hA5C3_0F96, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("stall_key_out", key_out, 32'hA5C3_0F96);

`ifdef KEY_PARITY_CHECK_EN
    // Parity failure, then recovery
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    loadKey(32'h0000_0001, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("parity_err", {31'b0, err}, 32'h1);
    checkOutput("parity_valid", {31'b0, key_valid}, 32'h0);
    checkOutput("parity_key_out", key_out, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("parity_po_out", po_out, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("parity_err_cleared", {31'b0, err}, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
`endif

    // clear together with beat 17
    k = 32'hA5C3_0F96;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) applyStimulus(1'b0, 1'b0, 1'b1, k[i]);
    applyStimulus(1'b0, 1'b1, 1'b1, k[17]);
    checkOutput("clear_key_out", key_out, 32'h0);
    checkOutput("clear_sready", {31'b0, key_sready}, 32'h0);
    checkOutput("clear_busy", {31'b0, busy}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("idle_ignores_beat", {31'b0, busy}, 32'h0);

    // Full load from IDLE after the clear, then reload a new key from ARMED
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    loadKey(32'hA5C3_0F96, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("after_clear_key_out", key_out, 32'hA5C3_0F96);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("reload_key_valid", {31'b0, key_valid}, 32'h0);
    checkOutput("reload_key_out", key_out, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reload_po_out", po_out, 32'h0);
    loadKey(32'h1234_5678, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reload_new_key", key_out, 32'h1234_5678);
    checkOutput("reload_new_valid", {31'b0, key_valid}, 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
